gold_nic: RTL and testbench



---
 rtl/gold_nic_if.sv | 31 +++
 rtl/gold_nic.sv | 102 ++++++++++
 tb/tb_gold_nic.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gold_nic_if.sv
// Processor register window and router local-port handshakes for gold_nic.
// The slave modport is the NIC view; master is the processor/router side.
interface gold_nic_if #(
  parameter int PACKET_SIZE = 64
);
  logic [1:0]             addr;
  logic [PACKET_SIZE-1:0] d_in;
  logic [PACKET_SIZE-1:0] d_out;
  logic                   nicEn;
  logic                   nicEnWR;

  logic                   net_si;
  logic                   net_ri;
  logic [PACKET_SIZE-1:0] net_di;
  logic                   net_so;
  logic                   net_ro;
  logic [PACKET_SIZE-1:0] net_do;
  logic                   net_polarity;

  modport slave (
    input  addr, d_in, nicEn, nicEnWR,
    input  net_si, net_di, net_ro, net_polarity,
    output d_out, net_ri, net_so, net_do
  );

  modport master (
    output addr, d_in, nicEn, nicEnWR,
    output net_si, net_di, net_ro, net_polarity,
    input  d_out, net_ri, net_so, net_do
  );
endinterface

// File: rtl/gold_nic.sv
// Network interface controller: one-entry input and output channels between a
// processor register window and a gold_router local port.
module gold_nic #(
  parameter int PACKET_SIZE = 64
) (
  input  logic     clk,
  input  logic     reset,
  gold_nic_if.slave bus
);
  localparam int VC_BIT = PACKET_SIZE - 1;

  typedef enum logic [1:0] {
    A_IN_BUF   = 2'b00,
    A_IN_STAT  = 2'b01,
    A_OUT_BUF  = 2'b10,
    A_OUT_STAT = 2'b11
  } addr_e;

  // Handshake semantics: a transfer happens on a rising edge where the sender's
  // send flag and the receiver's ready flag are both high in the same cycle.

  logic [PACKET_SIZE-1:0] in_buf;
  logic                   in_full;
  logic [PACKET_SIZE-1:0] out_buf;
  logic                   out_full;
  logic [PACKET_SIZE-1:0] d_out_q;

  logic                   rd_en;
  logic                   wr_en;
  addr_e                  sel;
  logic                   in_take;
  logic                   in_capture;
  logic                   out_load;
  logic                   out_send;
  logic [PACKET_SIZE-1:0] rd_data;

  always_comb begin
    sel        = addr_e'(bus.addr);
    rd_en      = bus.nicEn & ~bus.nicEnWR;
    wr_en      = bus.nicEn &  bus.nicEnWR;
    in_take    = rd_en & (sel == A_IN_BUF) & in_full;
    in_capture = bus.net_si & ~in_full;
    // A packet may only leave in the ring phase opposite to its VC bit.
    out_send   = out_full & bus.net_ro & (bus.net_polarity != out_buf[VC_BIT]);
    out_load   = wr_en & (sel == A_OUT_BUF) & ~out_full;
  end

  always_comb begin
    rd_data = '0;
    case (sel)
      A_IN_BUF:   rd_data    = in_buf;
      A_IN_STAT:  rd_data[0] = in_full;
      A_OUT_BUF:  rd_data    = out_buf;
      A_OUT_STAT: rd_data[0] = out_full;
      default:    rd_data    = '0;
    endcase
  end

  // Input channel: capture only when empty, free on a buffer read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_buf  <= '0;
      in_full <= 1'b0;
    end else begin
      if (in_capture) begin
        in_buf  <= bus.net_di;
        in_full <= 1'b1;
      end else if (in_take) begin
        in_full <= 1'b0;
      end
    end
  end

  // Output channel: writes while full are dropped; out_buf is kept after send.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_buf  <= '0;
      out_full <= 1'b0;
    end else begin
      if (out_load) begin
        out_buf  <= bus.d_in;
        out_full <= 1'b1;
      end else if (out_send) begin
        out_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out_q <= '0;
    end else if (rd_en) begin
      d_out_q <= rd_data;
    end
  end

  assign bus.d_out  = d_out_q;
  assign bus.net_ri = ~in_full;
  assign bus.net_so = out_send;
  assign bus.net_do = out_buf;

endmodule

// File: tb/tb_gold_nic.sv
// Directed and randomized bench for gold_nic against a queue-based channel model.
module tb_gold_nic;
  localparam int W = 64;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  gold_nic_if #(.PACKET_SIZE(W)) bus ();

  gold_nic #(.PACKET_SIZE(W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ring polarity: 0 out of reset, flips every cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.net_polarity <= 1'b0;
    else        bus.net_polarity <= ~bus.net_polarity;
  end

  // Reference model: each channel is a queue holding at most one packet.
  logic [W-1:0] in_q[$];
  logic [W-1:0] out_q[$];
  logic [W-1:0] last_in;
  logic [W-1:0] last_out;
  logic [W-1:0] m_dout;

  logic         obs_so;
  logic         obs_pol;
  logic [W-1:0] obs_do;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    in_q.delete();
    out_q.delete();
    last_in  = '0;
    last_out = '0;
    m_dout   = '0;
  endtask

  // One clock: check combinational outputs before the edge, advance the model,
  // then check the registered read data after the edge.
  task automatic tick();
    bit           rd;
    bit           wr10;
    bit           exp_so;
    logic [W-1:0] nd;
    @(negedge clk);
    exp_so = (out_q.size() != 0) && bus.net_ro && (bus.net_polarity != out_q[0][W-1]);
    chk("net_ri", bus.net_ri, (in_q.size() == 0));
    chk("net_so", bus.net_so, exp_so);
    chk("net_do", bus.net_do, last_out);
    obs_so  = bus.net_so;
    obs_pol = bus.net_polarity;
    obs_do  = bus.net_do;

    rd   = bus.nicEn && !bus.nicEnWR;
    wr10 = bus.nicEn && bus.nicEnWR && (bus.addr == 2'b10);
    nd   = m_dout;
    if (rd) begin
      case (bus.addr)
        2'b00:   nd = (in_q.size() != 0) ? in_q[0] : last_in;
        2'b01:   nd = W'(in_q.size());
        2'b10:   nd = last_out;
        default: nd = W'(out_q.size());
      endcase
    end
    if (rd && bus.addr == 2'b00 && in_q.size() != 0) begin
      void'(in_q.pop_front());
    end else if (bus.net_si && in_q.size() == 0) begin
      in_q.push_back(bus.net_di);
      last_in = bus.net_di;
    end
    if (wr10 && out_q.size() == 0) begin
      out_q.push_back(bus.d_in);
      last_out = bus.d_in;
    end else if (exp_so) begin
      void'(out_q.pop_front());
    end
    m_dout = nd;

    @(posedge clk);
    #1;
    chk("d_out", bus.d_out, m_dout);
  endtask

  task automatic access(input bit wr, input logic [1:0] a, input logic [W-1:0] d);
    bus.nicEn   = 1'b1;
    bus.nicEnWR = wr;
    bus.addr    = a;
    bus.d_in    = d;
    tick();
    bus.nicEn   = 1'b0;
    bus.nicEnWR = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_net_so", bus.net_so, 0);
    chk("rst_net_ri", bus.net_ri, 1);
    chk("rst_d_out", bus.d_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    bit           saw;
    logic         sp;
    logic [W-1:0] sd;
    bit           stall_so;

    checks   = 0;
    failures = 0;
    model_clear();
    obs_so = 1'b0; obs_pol = 1'b0; obs_do = '0;
    rst_n       = 1'b0;
    bus.addr    = 2'b00;
    bus.d_in    = '0;
    bus.nicEn   = 1'b0;
    bus.nicEnWR = 1'b0;
    bus.net_si  = 1'b1;
    bus.net_di  = 64'hDEAD_BEEF_0000_0001;
    bus.net_ro  = 1'b1;

    // Reset held for three cycles with the router trying to send.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_net_ri", bus.net_ri, 1);
    chk("reset_net_so", bus.net_so, 0);
    chk("reset_d_out", bus.d_out, 0);
    chk("reset_net_do", bus.net_do, 0);
    bus.net_si = 1'b0;
    rst_n = 1'b1;
    access(1'b0, 2'b01, '0);
    chk("reset_in_stat", bus.d_out, 0);
    access(1'b0, 2'b11, '0);
    chk("reset_out_stat", bus.d_out, 0);

    // Receive, then back-pressure while full.
    bus.net_si = 1'b1;
    bus.net_di = 64'hA5A5_0000_0000_1234;
    tick();
    chk("rx_ri_busy", bus.net_ri, 0);
    bus.net_di = 64'h0000_0000_0000_BEEF;
    tick();
    bus.net_si = 1'b0;
    access(1'b0, 2'b01, '0);
    chk("rx_in_stat", bus.d_out, 1);
    access(1'b0, 2'b00, '0);
    chk("rx_data", bus.d_out, 64'hA5A5_0000_0000_1234);
    chk("rx_ri_free", bus.net_ri, 1);

    // Inject a VC=1 packet: it may only leave while polarity is 0.
    bus.net_ro = 1'b1;
    access(1'b1, 2'b10, 64'h8000_0000_0000_0042);
    saw = 1'b0; sp = 1'b1; sd = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (obs_so && !saw) begin
        saw = 1'b1; sp = obs_pol; sd = obs_do;
      end
    end
    chk("inj_sent", saw, 1);
    chk("inj_polarity", sp, 0);
    chk("inj_data", sd, 64'h8000_0000_0000_0042);
    access(1'b0, 2'b11, '0);
    chk("inj_out_stat", bus.d_out, 0);

    // Router stall: packet held, a second write is dropped.
    bus.net_ro = 1'b0;
    access(1'b1, 2'b10, 64'h0000_0000_0000_0077);
    stall_so = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      stall_so = stall_so | obs_so;
    end
    chk("stall_no_so", stall_so, 0);
    access(1'b0, 2'b11, '0);
    chk("stall_out_stat", bus.d_out, 1);
    access(1'b1, 2'b10, 64'h1);
    bus.net_ro = 1'b1;
    saw = 1'b0; sd = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (obs_so && !saw) begin
        saw = 1'b1; sd = obs_do;
      end
    end
    chk("stall_sent", saw, 1);
    chk("stall_data", sd, 64'h0000_0000_0000_0077);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.nicEn   = ($urandom_range(0, 2) != 0);
      bus.nicEnWR = $urandom_range(0, 1);
      bus.addr    = 2'($urandom_range(0, 3));
      bus.d_in    = {$urandom, $urandom};
      bus.net_si  = $urandom_range(0, 1);
      bus.net_di  = {$urandom, $urandom};
      bus.net_ro  = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.nicEn  = 1'b0;
    bus.net_si = 1'b0;

    // Reset while both buffers hold packets.
    bus.net_ro = 1'b0;
    access(1'b0, 2'b00, '0);
    bus.net_si = 1'b1;
    bus.net_di = 64'h1111_2222_3333_4444;
    access(1'b1, 2'b11, '0);
    bus.net_si = 1'b0;
    access(1'b0, 2'b11, '0);
    if (out_q.size() == 0) access(1'b1, 2'b10, 64'h0000_0000_0000_0055);
    access(1'b0, 2'b01, '0);
    chk("pre_rst_in_full", bus.d_out, 1);
    access(1'b0, 2'b11, '0);
    chk("pre_rst_out_full", bus.d_out, 1);
    pulse_reset();
    bus.net_ro = 1'b1;
    chk("post_rst_so", bus.net_so, 0);
    access(1'b0, 2'b01, '0);
    chk("post_rst_in_stat", bus.d_out, 0);
    access(1'b0, 2'b11, '0);
    chk("post_rst_out_stat", bus.d_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
